// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch FSM states and queue entry type for the cpu core
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int CMD_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry registered queue of fetched commands with flush
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_head;
    fetch_entry_t r_tail;
    logic [1:0]   r_count;

    // Head always lives in r_head so the downstream view comes straight from a register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_entry;
                    end else begin
                        r_tail <= i_entry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_entry;
                    end else begin
                        r_head <= i_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/cmd_fetch.sv
// rtl/cmd_fetch.sv - instruction fetch stage: PC walk, command memory handshake, redirect and halt
module cmd_fetch #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CMD_W  = cpu_pkg::CMD_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cmd_req,
    output logic [ADDR_W-1:0] cmd_adr,
    input  logic              cmd_ack,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [CMD_W-1:0]  instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    import cpu_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_next;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [1:0]        w_count_next;
    logic              w_space;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;

    assign cmd_req     = (r_state != IDLE);
    assign cmd_adr     = r_pc;
    assign instr_valid = (w_count != 2'd0);
    assign instr       = w_head.cmd;
    assign instr_pc    = w_head.pc;

    // Only a WAIT-state ack carries live data; DRAIN acks belong to a flushed path.
    assign w_push = (r_state == WAIT) && cmd_ack && !redirect;
    assign w_pop  = instr_valid && instr_ready && !redirect;

    assign w_count_next = redirect ? 2'd0 : (w_count + {1'b0, w_push} - {1'b0, w_pop});
    assign w_space      = (w_count_next < 2'd2);

    assign w_entry.cmd = cmd_data;
    assign w_entry.pc  = r_pc;

    fetch_fifo u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_pend_pc <= RESET_PC;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_pend_pc <= w_pend_pc_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_pend_pc_next = r_pend_pc;
        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_pc_next = redirect_pc;
                end
                if (!halt && w_space) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (cmd_ack) begin
                    if (redirect) begin
                        w_pc_next    = redirect_pc;
                        w_state_next = halt ? IDLE : WAIT;
                    end else begin
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = (!halt && w_space) ? WAIT : IDLE;
                    end
                end else if (redirect) begin
                    // Request must stay stable until acked, so the target is parked.
                    w_pend_pc_next = redirect_pc;
                    w_state_next   = DRAIN;
                end
            end
            DRAIN: begin
                if (cmd_ack) begin
                    w_pc_next    = redirect ? redirect_pc : r_pend_pc;
                    w_state_next = halt ? IDLE : WAIT;
                end else if (redirect) begin
                    w_pend_pc_next = redirect_pc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmd_fetch.sv
// tb/tb_cmd_fetch.sv - directed self-checking bench for cmd_fetch
module tb_cmd_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_req;
    logic [3:0]  cmd_adr;
    logic        cmd_ack;
    logic [15:0] cmd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  instr_pc;
    logic        redirect;
    logic [3:0]  redirect_pc;
    logic        halt;

    logic        auto_ack;
    logic        man_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Memory model: zero-wait when auto_ack is set, otherwise ack is driven by hand.
    assign cmd_ack  = auto_ack ? cmd_req : man_ack;
    assign cmd_data = {12'hA00, cmd_adr};

    cmd_fetch #(.ADDR_W(4), .CMD_W(16), .RESET_PC(4'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_req     (cmd_req),
        .cmd_adr     (cmd_adr),
        .cmd_ack     (cmd_ack),
        .cmd_data    (cmd_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        auto_ack = 1'b0; man_ack = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 4'd0; halt = 1'b0;
        do_reset();
        n_checks++;
        if ({cmd_req, instr_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ctrl got req=%b valid=%b exp req=0 valid=0", cmd_req, instr_valid);
        end
        n_checks++;
        if ({cmd_adr, instr, instr_pc} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_data got adr=%h instr=%h pc=%h exp all 0", cmd_adr, instr, instr_pc);
        end
        step();
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd0) begin
            n_errors++;
            $display("FAIL first_req got req=%b adr=%h exp req=1 adr=0", cmd_req, cmd_adr);
        end
    endtask

    task automatic test_streaming;
        logic [3:0] e;
        auto_ack = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        for (int i = 0; i < 17; i++) begin
            step();
            e = i[3:0];
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== {12'hA00, e} || instr_pc !== e) begin
                n_errors++;
                $display("FAIL stream_%0d got valid=%b instr=%h pc=%h exp valid=1 instr=%h pc=%h",
                         i, instr_valid, instr, instr_pc, {12'hA00, e}, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acks;
        int pops;
        logic [3:0] e;
        auto_ack = 1'b1; instr_ready = 1'b0;
        do_reset();
        step();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_req && cmd_ack) acks++;
            step();
        end
        n_checks++;
        if (acks !== 2 || cmd_req !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_acks got acks=%0d req=%b exp acks=2 req=0", acks, cmd_req);
        end
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'hA000) begin
            n_errors++;
            $display("FAIL bp_head got valid=%b instr=%h exp valid=1 instr=a000", instr_valid, instr);
        end
        instr_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 20 && pops < 6; i++) begin
            if (instr_valid) begin
                e = pops[3:0];
                n_checks++;
                if (instr !== {12'hA00, e} || instr_pc !== e) begin
                    n_errors++;
                    $display("FAIL bp_order_%0d got instr=%h pc=%h exp instr=%h pc=%h",
                             pops, instr, instr_pc, {12'hA00, e}, e);
                end
                pops++;
            end
            step();
        end
        n_checks++;
        if (pops !== 6) begin
            n_errors++;
            $display("FAIL bp_drain got pops=%0d exp 6", pops);
        end
    endtask

    task automatic test_redirect_wait;
        auto_ack = 1'b0; man_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        step();
        step();
        redirect = 1'b1; redirect_pc = 4'd9;
        step();
        redirect = 1'b0;
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rdw_drain got req=%b adr=%h valid=%b exp req=1 adr=0 valid=0",
                     cmd_req, cmd_adr, instr_valid);
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd9 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rdw_target got req=%b adr=%h valid=%b exp req=1 adr=9 valid=0",
                     cmd_req, cmd_adr, instr_valid);
        end
        auto_ack = 1'b1;
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 4'd9 || instr !== 16'hA009) begin
            n_errors++;
            $display("FAIL rdw_first got valid=%b pc=%h instr=%h exp valid=1 pc=9 instr=a009",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_ack_redirect;
        auto_ack = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        redirect = 1'b1; redirect_pc = 4'd4;
        step();
        redirect = 1'b0;
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd4 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ackrd_next got req=%b adr=%h valid=%b exp req=1 adr=4 valid=0",
                     cmd_req, cmd_adr, instr_valid);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 4'd4 || instr !== 16'hA004) begin
            n_errors++;
            $display("FAIL ackrd_first got valid=%b pc=%h instr=%h exp valid=1 pc=4 instr=a004",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_halt;
        int reqs;
        auto_ack = 1'b1; man_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        step();
        for (int k = 0; k < 20 && cmd_adr != 4'd5; k++) step();
        auto_ack = 1'b0;
        halt = 1'b1;
        step();
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd5) begin
            n_errors++;
            $display("FAIL halt_hold got req=%b adr=%h exp req=1 adr=5", cmd_req, cmd_adr);
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (cmd_req !== 1'b0 || instr_valid !== 1'b1 || instr !== 16'hA005 || instr_pc !== 4'd5) begin
            n_errors++;
            $display("FAIL halt_deliver got req=%b valid=%b instr=%h pc=%h exp req=0 valid=1 instr=a005 pc=5",
                     cmd_req, instr_valid, instr, instr_pc);
        end
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cmd_req) reqs++;
        end
        n_checks++;
        if (reqs !== 0) begin
            n_errors++;
            $display("FAIL halt_idle got req_cycles=%0d exp 0", reqs);
        end
        halt = 1'b0;
        step();
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd6) begin
            n_errors++;
            $display("FAIL halt_resume got req=%b adr=%h exp req=1 adr=6", cmd_req, cmd_adr);
        end
    endtask

    task automatic test_reset_mid;
        auto_ack = 1'b1; instr_ready = 1'b0;
        do_reset();
        step();
        step();
        auto_ack = 1'b0;
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd1 || instr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_pre got req=%b adr=%h valid=%b exp req=1 adr=1 valid=1",
                     cmd_req, cmd_adr, instr_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (cmd_req !== 1'b0 || instr_valid !== 1'b0 || cmd_adr !== 4'd0) begin
            n_errors++;
            $display("FAIL rstmid_clear got req=%b valid=%b adr=%h exp req=0 valid=0 adr=0",
                     cmd_req, instr_valid, cmd_adr);
        end
        step();
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_adr !== 4'd0) begin
            n_errors++;
            $display("FAIL rstmid_restart got req=%b adr=%h exp req=1 adr=0", cmd_req, cmd_adr);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back();
        test_redirect_wait();
        test_ack_redirect();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmd_fetch.md
# cmd_fetch

Instruction fetch stage of the `cpu` core. It sits between the command memory and the decode/ALU stage. It walks a program counter, runs a req/ack handshake with the command memory, and buffers fetched commands in a 2-entry queue. It presents them downstream with a valid/ready handshake and supports branch redirect and halt.

## Interface
- `ADDR_W`, default 4: command address width, equal to the memory address width.
- `CMD_W`, default 16: command word width.
- `RESET_PC`, default 0: PC value after reset.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_req`  out  1  fetch request to the command memory.
- `cmd_adr`  out  ADDR_W  fetch address; stable while `cmd_req` is high.
- `cmd_ack`  in  1  memory ack; meaningful only while `cmd_req` is high.
- `cmd_data`  in  CMD_W  command word, valid in the `cmd_ack` cycle.
- `instr_valid`  out  1  queue head is valid.
- `instr_ready`  in  1  downstream accepts the head.
- `instr`  out  CMD_W  head command word.
- `instr_pc`  out  ADDR_W  address of the head command.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  redirect target.
- `halt`  in  1  level signal: no new requests are launched while high.

## Operation
- The memory handshake completes on the edge where `cmd_req && cmd_ack`. Once `cmd_req` rises, it and `cmd_adr` hold until ack. A request is never withdrawn, except by `rst`.
- Downstream pop happens on the edge where `instr_valid && instr_ready`.
- Queue: 2 entries of {cmd_data, cmd_adr}; `count` is 0..2. Push and pop may occur in the same cycle.
- PC: `cmd_adr` is the PC. On an accepted (non-discarded) ack, PC <= PC+1 mod 2^ADDR_W, so 15 wraps to 0.
- `space` = (count after this cycle's push/pop) < 2.
- FSM states:
  - IDLE: `cmd_req`=0. Goes to WAIT next cycle if !halt && space.
  - WAIT: `cmd_req`=1.
    - On ack without redirect: push, then WAIT if !halt && space, else IDLE.
    - On ack with redirect: discard data, PC <= redirect_pc, then WAIT if !halt, else IDLE.
    - Redirect without ack: PC update is deferred, go to DRAIN.
  - DRAIN: `cmd_req`=1 at the old address; the ack data is discarded.
    - On ack: PC <= pending target, then WAIT if !halt, else IDLE.
    - A further redirect in DRAIN overwrites the pending target.
- Redirect in any state flushes the queue (count <= 0) on that edge. A same-cycle pop is ignored.
- Halt does not cancel an outstanding request; that ack is still pushed. The PC is retained, and fetch resumes in order when halt drops.
- No memory ack arrives while `cmd_req`=0; any such ack is ignored.

## Timing
- Reset values: `cmd_req`=0, `cmd_adr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, state IDLE, count 0.
- The first `cmd_req` is high on the cycle after `rst` deasserts (with `halt` low).
- Ack-to-`instr_valid` latency is 1 cycle; queue outputs are registered.
- Zero-wait memory (ack in the same cycle as req) with a ready consumer sustains one command per cycle. `cmd_req` stays high and `cmd_adr` increments every cycle.
- Full queue with no pop: `cmd_req` drops the cycle after the second push.
- `rst` mid-request: all state returns to reset values on that edge, and `cmd_req` falls. The memory must tolerate an abandoned request.
- There are no combinational paths from `instr_ready` or `cmd_ack` to `cmd_req`/`cmd_adr`.

## Structure
- `cpu_pkg` holds:
  - `ADDR_W` and `CMD_W` constants.
  - `fetch_state_t` enum {IDLE, WAIT, DRAIN}.
  - The packed struct `fetch_entry_t` {cmd, pc}.
- Sub-module `fetch_fifo`: 2-entry registered FIFO of `fetch_entry_t` with push, pop, flush and count. `cmd_fetch` holds the FSM and PC.

## Test plan
- Streaming: reset, zero-wait memory returning `cmd_data` = 16'hA000+adr, `instr_ready`=1. Required: `instr` sequence A000, A001, …, A00F, A000, with `instr_pc` wrapping 15 to 0 and one command per cycle.
- Back-pressure: `instr_ready`=0 for 10 cycles. Required: exactly 2 acks, then `cmd_req`=0 and head `instr`=A000. On releasing ready, the order is preserved with no loss or duplicates.
- Redirect during wait: memory delays ack 3 cycles and `redirect`/`redirect_pc`=9 pulses in wait cycle 1. Required: the old ack data is never seen, the queue is empty, and the next `cmd_adr`=9 with `instr_pc`=9 first.
- Same-cycle ack and redirect to 4: ack data discarded; the next request is at `cmd_adr`=4.
- Halt: `halt` raised mid-request at adr 5. Required: adr 5 is delivered, then no `cmd_req`. Dropping `halt` resumes at adr 6.
- Reset mid-request: `rst` pulsed while `cmd_req`=1. Required: next cycle `cmd_req`=0 and `instr_valid`=0, then fetch restarts at RESET_PC.
